ibex_multdiv_issue: RTL and testbench

Issue-side sequencer for the iterative multiply/divide unit in the ID stage. It accepts one mult/div operation at a time through a valid/ready request port and holds operands and control stable toward the unit. It keeps the unit enabled exactly as long as the unit's protocol requires, then captures the 32-bit result and presents it to writeback through a valid/ready result port. Flushes are absorbed by draining the unit, which has no abort.

---
 rtl/ibex_multdiv_issue.sv | 100 ++++++++++
 tb/tb_ibex_multdiv_issue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_issue.sv
// ibex_multdiv_issue: issue sequencer for the iterative mult/div unit.
// Defining MULTDIV_OPCACHE_EN adds a one-entry result cache that bypasses the unit on a repeat request.
module ibex_multdiv_issue (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_operator_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_op_a_i,
  input  logic [31:0] req_op_b_i,
  input  logic        flush_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic        mult_en_o,
  output logic        div_en_o,
  output logic [1:0]  operator_o,
  output logic [1:0]  signed_mode_o,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_e;
  state_e      state_q, state_d;
  logic [1:0]  operator_q, operator_d, signed_mode_q, signed_mode_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic        accept, complete, running, hit;
  logic [31:0] hit_res;
  assign req_ready_o   = (state_q == IDLE || (state_q == DONE && res_ready_i)) && !flush_i;
  assign accept        = req_valid_i && req_ready_o;
  assign complete      = state_q == BUSY && md_valid_i && !flush_i;
  // The unit has no abort, so the enable stays up through DRAIN until it reports done.
  assign running       = state_q == BUSY || state_q == DRAIN;
  assign mult_en_o     = running && !operator_q[1];
  assign div_en_o      = running && operator_q[1];
  assign res_valid_o   = state_q == DONE;
  assign res_data_o    = res_q;
  assign operator_o    = operator_q;
  assign signed_mode_o = signed_mode_q;
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
`ifdef MULTDIV_OPCACHE_EN
  logic        c_valid_q;
  logic [1:0]  c_operator_q, c_signed_mode_q;
  logic [31:0] c_op_a_q, c_op_b_q, c_res_q;
  assign hit = c_valid_q && c_operator_q == req_operator_i && c_signed_mode_q == req_signed_mode_i &&
               c_op_a_q == req_op_a_i && c_op_b_q == req_op_b_i;
  assign hit_res = c_res_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_valid_q       <= 1'b0;
      c_operator_q    <= '0;
      c_signed_mode_q <= '0;
      c_op_a_q        <= '0;
      c_op_b_q        <= '0;
      c_res_q         <= '0;
    end else if (complete) begin
      c_valid_q       <= 1'b1;
      c_operator_q    <= operator_q;
      c_signed_mode_q <= signed_mode_q;
      c_op_a_q        <= op_a_q;
      c_op_b_q        <= op_b_q;
      c_res_q         <= md_result_i;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif
  always_comb begin
    state_d       = accept ? (hit ? DONE : BUSY) :
                    state_q == BUSY  ? (flush_i ? DRAIN : (md_valid_i ? DONE : BUSY)) :
                    state_q == DRAIN ? (md_valid_i ? IDLE : DRAIN) :
                    (state_q == DONE && (flush_i || res_ready_i)) ? IDLE : state_q;
    operator_d    = accept ? req_operator_i : operator_q;
    signed_mode_d = accept ? req_signed_mode_i : signed_mode_q;
    op_a_d        = accept ? req_op_a_i : op_a_q;
    op_b_d        = accept ? req_op_b_i : op_b_q;
    res_d         = (accept && hit) ? hit_res : (complete ? md_result_i : res_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      operator_q    <= '0;
      signed_mode_q <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      res_q         <= '0;
    end else begin
      state_q       <= state_d;
      operator_q    <= operator_d;
      signed_mode_q <= signed_mode_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      res_q         <= res_d;
    end
  end
endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// tb_ibex_multdiv_issue: vector table, corner sequences and random ops against an
// arithmetic model, with a latency-accurate stand-in for the mult/div unit.
module tb_ibex_multdiv_issue;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [1:0]  req_operator_i = '0, req_signed_mode_i = '0;
  logic [31:0] req_op_a_i = '0, req_op_b_i = '0;
  logic        flush_i = 1'b0, res_valid_o, res_ready_i = 1'b0;
  logic [31:0] res_data_o;
  logic        mult_en_o, div_en_o;
  logic [1:0]  operator_o, signed_mode_o;
  logic [31:0] op_a_o, op_b_o;
  logic        md_valid_i;
  logic [31:0] md_result_i;
  int tests = 0, fails = 0;
`ifdef MULTDIV_OPCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  always #5 clk_i = ~clk_i;
  ibex_multdiv_issue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .flush_i(flush_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o), .operator_o(operator_o),
    .signed_mode_o(signed_mode_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
    .md_valid_i(md_valid_i), .md_result_i(md_result_i));

  function automatic logic [31:0] ref_res(logic [1:0] op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
    if (!op[1]) r = sa * sb;
    else if (b == 0) r = op[0] ? {32'd0, a} : '1;
    else r = op[0] ? sa % sb : sa / sb;
    return op == 2'd1 ? r[63:32] : r[31:0];
  endfunction

  // Unit stand-in: done after 33 (mult), 37 (div) or 2 (div by zero) enabled cycles; result from held operands.
  int   ucnt;
  logic uen;
  assign uen = mult_en_o | div_en_o;
  assign md_valid_i = uen && (ucnt + 1 == (mult_en_o ? 33 : (op_b_o == 0 ? 2 : 37)));
  always_comb md_result_i = md_valid_i ? ref_res(operator_o, signed_mode_o, op_a_o, op_b_o) : 32'hDEADBEEF;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ucnt <= 0;
    else ucnt <= (uen && !md_valid_i) ? ucnt + 1 : 0;

  logic        c_v = 1'b0;
  logic [67:0] c_key;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic consume;
    res_ready_i = 1'b1;
    step;
    res_ready_i = 1'b0;
    check("consume drops valid", res_valid_o, 0);
  endtask

  task automatic issue(logic [1:0] op, logic [1:0] sm, logic [31:0] a, logic [31:0] b, bit b2b);
    req_valid_i = 1'b1; req_operator_i = op; req_signed_mode_i = sm;
    req_op_a_i = a; req_op_b_i = b; res_ready_i = b2b;
    #1;
    check("req_ready", req_ready_o, 1);
    step;
    req_valid_i = 1'b0; res_ready_i = 1'b0;
  endtask

  task automatic run(string name, logic [1:0] op, logic [1:0] sm, logic [31:0] a, logic [31:0] b,
                     logic [31:0] want, bit b2b);
    int lat, k, en_cnt;
    bit hit;
    if (res_valid_o && !b2b) consume;
    hit = CACHE && c_v && c_key == {op, sm, a, b};
    lat = hit ? 1 : (!op[1] ? 34 : (b == 0 ? 3 : 38));
    issue(op, sm, a, b, b2b);
    k = 1; en_cnt = 0;
    while (!res_valid_o && k < 60) begin
      en_cnt += int'(uen);
      step;
      k++;
    end
    check({name, " latency"}, k, lat);
    check({name, " enable cycles"}, en_cnt, hit ? 0 : lat - 1);
    check({name, " enable low in done"}, uen, 0);
    check({name, " data"}, res_data_o, want);
    if (!hit) begin c_v = 1'b1; c_key = {op, sm, a, b}; end
  endtask

  typedef struct {
    logic [1:0]  op, sm;
    logic [31:0] a, b, want;
    bit          b2b;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 2'd0, 32'd7, 32'd6, 32'd42, 1'b0};
    tbl[1] = '{2'd0, 2'd0, 32'd7, 32'd6, 32'd42, 1'b0};
    tbl[2] = '{2'd1, 2'd3, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    tbl[3] = '{2'd2, 2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0};
    tbl[4] = '{2'd3, 2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b1};
    tbl[5] = '{2'd2, 2'd0, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0};
    step; step;
    check("rst res_valid", res_valid_o, 0);
    check("rst res_data", res_data_o, 0);
    check("rst mult_en", mult_en_o, 0);
    check("rst div_en", div_en_o, 0);
    check("rst operator", operator_o, 0);
    check("rst signed_mode", signed_mode_o, 0);
    check("rst op_a", op_a_o, 0);
    check("rst op_b", op_b_o, 0);
    check("rst req_ready", req_ready_o, 1);
    rst_ni = 1'b1;
    step;
    for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), tbl[i].op, tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].want, tbl[i].b2b);
    // request under flush in IDLE is ignored
    consume;
    req_valid_i = 1'b1; req_operator_i = 2'd1; req_op_a_i = 32'd3; flush_i = 1'b1;
    #1;
    check("idle flush ready", req_ready_o, 0);
    step;
    req_valid_i = 1'b0; flush_i = 1'b0;
    check("idle flush no enable", uen, 0);
    check("idle flush operator held", operator_o, 2);
    // flush in BUSY cycle 10 of a MULL: drain until the unit finishes
    begin
      int k, md_k;
      bit seen_valid, en_gap;
      issue(2'd0, 2'd0, 32'h1234, 32'h55, 1'b0);
      for (k = 1; k < 10; k++) step;
      flush_i = 1'b1;
      step;
      flush_i = 1'b0;
      k = 11; md_k = 0; seen_valid = 0; en_gap = 0;
      while (md_k == 0 && k < 60) begin
        seen_valid |= res_valid_o;
        en_gap |= !mult_en_o;
        if (md_valid_i) md_k = k; else begin step; k++; end
      end
      check("drain md cycle", md_k, 33);
      check("drain enable held", en_gap, 0);
      step;
      seen_valid |= res_valid_o;
      check("drain no res_valid", seen_valid, 0);
      check("drain ready after", req_ready_o, 1);
      check("drain enable low", uen, 0);
    end
    // flush coinciding with md_valid: result discarded, unit run again in DRAIN
    begin
      int k;
      issue(2'd2, 2'd0, 32'd5, 32'd0, 1'b0);
      step;
      check("flush@md md_valid", md_valid_i, 1);
      flush_i = 1'b1;
      step;
      flush_i = 1'b0;
      check("flush@md drain enable", div_en_o, 1);
      check("flush@md no valid", res_valid_o, 0);
      k = 0;
      while (!md_valid_i && k < 10) begin step; k++; end
      check("flush@md drain md", md_valid_i, 1);
      step;
      check("flush@md idle ready", req_ready_o, 1);
      check("flush@md no valid after", res_valid_o, 0);
    end
    run("div0 uncached", 2'd2, 2'd0, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0);
    // flush in DONE drops the result
    flush_i = 1'b1;
    #1;
    check("done flush ready", req_ready_o, 0);
    step;
    flush_i = 1'b0;
    check("done flush drops valid", res_valid_o, 0);
    for (int i = 0; i < 20; i++) begin
      logic [1:0] op, sm;
      logic [31:0] a, b;
      if (c_v && $urandom_range(0, 3) == 0) {op, sm, a, b} = c_key;
      else begin
        op = 2'($urandom_range(0, 3));
        sm = op[1] ? ($urandom_range(0, 1) ? 2'd3 : 2'd0) : 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom_range(0, 4) == 0 ? 32'd0 : $urandom;
      end
      run($sformatf("rnd%0d", i), op, sm, a, b, ref_res(op, sm, a, b), res_valid_o && $urandom_range(0, 1) == 1);
    end
    // asynchronous reset in the middle of a divide
    consume;
    issue(2'd2, 2'd3, 32'd100, 32'd7, 1'b0);
    step; step;
    rst_ni = 1'b0;
    #1;
    check("midrst enable", uen, 0);
    check("midrst valid", res_valid_o, 0);
    check("midrst operator", operator_o, 0);
    check("midrst op_a", op_a_o, 0);
    step;
    rst_ni = 1'b1;
    c_v = 1'b0;
    step;
    check("midrst ready", req_ready_o, 1);
    run("post reset mull", 2'd0, 2'd0, 32'd7, 32'd6, 32'd42, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
